progmem_arbiter: RTL and testbench

Arbitrates the single-port program memory between the CPU instruction-fetch port and the loader/debug port (read/write). Issues at most one memory access per clock, routes the 1-cycle-latency registered read data back to the requester that owns it, and bounds loader priority so fetch cannot starve. Sits between the CPU core / loader and the progmem instance.

---
 rtl/progmem_arbiter_if.sv | 33 +++
 rtl/progmem_arbiter.sv | 77 +++++++
 tb/tb_progmem_arbiter.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/progmem_arbiter_if.sv
// rtl/progmem_arbiter_if.sv - fetch, loader and progmem bus bundle for progmem_arbiter
// slave is the arbiter's view; master is the CPU/loader/memory side.
interface progmem_arbiter_if;
   logic        fetch_req;
   logic [15:0] fetch_addr;
   logic        fetch_gnt;
   logic        fetch_rvalid;
   logic [15:0] fetch_rdata;
   logic        ldr_req;
   logic        ldr_we;
   logic [15:0] ldr_addr;
   logic [15:0] ldr_wdata;
   logic        ldr_gnt;
   logic        ldr_rvalid;
   logic [15:0] ldr_rdata;
   logic        wp_err;
   logic [15:0] mem_addr;
   logic [15:0] mem_din;
   logic        mem_we;
   logic [15:0] mem_dout;

   modport slave (
      input  fetch_req, fetch_addr, ldr_req, ldr_we, ldr_addr, ldr_wdata, mem_dout,
      output fetch_gnt, fetch_rvalid, fetch_rdata, ldr_gnt, ldr_rvalid, ldr_rdata,
             wp_err, mem_addr, mem_din, mem_we
   );

   modport master (
      output fetch_req, fetch_addr, ldr_req, ldr_we, ldr_addr, ldr_wdata, mem_dout,
      input  fetch_gnt, fetch_rvalid, fetch_rdata, ldr_gnt, ldr_rvalid, ldr_rdata,
             wp_err, mem_addr, mem_din, mem_we
   );
endinterface

// File: rtl/progmem_arbiter.sv
// rtl/progmem_arbiter.sv - single-port progmem arbiter, fetch vs loader with bounded loader burst
// Optional write protection below WP_LIMIT: define PROGMEM_WP_EN.
module progmem_arbiter #(
   parameter int          MAX_LDR_BURST = 4,
   parameter logic [15:0] WP_LIMIT      = 16'h0010
) (
   input logic            clk,
   input logic            resetn,
   progmem_arbiter_if.slave bus
);

   localparam logic [3:0] BURST_MAX = 4'(MAX_LDR_BURST);

   logic [3:0] burst_cnt;
   logic       fetch_own;
   logic       ldr_own;
   logic       burst_full;
   logic       ldr_gnt;
   logic       fetch_gnt;
   logic       wp_block;

   // Loader has priority until it has taken BURST_MAX slots while fetch waits.
   assign burst_full = (burst_cnt == BURST_MAX);
   assign ldr_gnt    = bus.ldr_req & ~(bus.fetch_req & burst_full);
   assign fetch_gnt  = bus.fetch_req & ~ldr_gnt;

   assign bus.ldr_gnt   = ldr_gnt;
   assign bus.fetch_gnt = fetch_gnt;

`ifdef PROGMEM_WP_EN
   logic wp_err_q;

   assign wp_block   = bus.ldr_we & (bus.ldr_addr < WP_LIMIT);
   assign bus.wp_err = wp_err_q;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wp_err_q <= 1'b0;
      end else begin
         wp_err_q <= ldr_gnt & wp_block;
      end
   end
`else
   logic unused_wp;

   assign unused_wp  = ^WP_LIMIT;
   assign wp_block   = 1'b0;
   assign bus.wp_err = 1'b0;
`endif

   // With no grant the fetch address is presented and nothing is written.
   assign bus.mem_addr = ldr_gnt ? bus.ldr_addr : bus.fetch_addr;
   assign bus.mem_din  = bus.ldr_wdata;
   assign bus.mem_we   = resetn & ldr_gnt & bus.ldr_we & ~wp_block;

   assign bus.fetch_rvalid = fetch_own;
   assign bus.ldr_rvalid   = ldr_own;
   assign bus.fetch_rdata  = bus.mem_dout;
   assign bus.ldr_rdata    = bus.mem_dout;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         burst_cnt <= 4'd0;
         fetch_own <= 1'b0;
         ldr_own   <= 1'b0;
      end else begin
         fetch_own <= fetch_gnt;
         ldr_own   <= ldr_gnt & ~bus.ldr_we;
         if (!bus.fetch_req || fetch_gnt) begin
            burst_cnt <= 4'd0;
         end else if (ldr_gnt && !burst_full) begin
            burst_cnt <= burst_cnt + 4'd1;
         end
      end
   end

endmodule

// File: tb/tb_progmem_arbiter.sv
// tb/tb_progmem_arbiter.sv - scoreboard bench for progmem_arbiter with a behavioural progmem
module tb_progmem_arbiter;

`ifdef PROGMEM_WP_EN
   localparam bit WP = 1'b1;
`else
   localparam bit WP = 1'b0;
`endif

   typedef struct {
      logic        fg;
      logic        lg;
      logic        we;
      logic [15:0] ma;
      logic        fv;
      logic        lv;
      logic        wp;
   } cyc_exp_t;

   logic clk = 1'b0;
   logic resetn;
   int   n_cmp = 0;
   int   n_err = 0;

   cyc_exp_t    exp_q[$];
   logic [15:0] fq[$];
   logic [15:0] lq[$];
   logic [15:0] mem [0:255];

   progmem_arbiter_if bus ();

   progmem_arbiter #(.MAX_LDR_BURST(4), .WP_LIMIT(16'h0010)) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (bus.mem_we) mem[bus.mem_addr[7:0]] <= bus.mem_din;
      bus.mem_dout <= mem[bus.mem_addr[7:0]];
   end

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] expv);
      n_cmp++;
      if (act !== expv) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
      end
   endtask

   // Monitor: per-cycle expectations plus read-data scoreboard on each rvalid.
   always @(negedge clk) begin
      cyc_exp_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk("fetch_gnt", 16'(bus.fetch_gnt), 16'(e.fg));
         chk("ldr_gnt", 16'(bus.ldr_gnt), 16'(e.lg));
         chk("mem_we", 16'(bus.mem_we), 16'(e.we));
         chk("mem_addr", bus.mem_addr, e.ma);
         chk("fetch_rvalid", 16'(bus.fetch_rvalid), 16'(e.fv));
         chk("ldr_rvalid", 16'(bus.ldr_rvalid), 16'(e.lv));
         chk("wp_err", 16'(bus.wp_err), 16'(e.wp));
      end
      if (bus.fetch_rvalid === 1'b1) begin
         if (fq.size() == 0) chk("fetch_rvalid_unexpected", 16'd1, 16'd0);
         else chk("fetch_rdata", bus.fetch_rdata, fq.pop_front());
      end
      if (bus.ldr_rvalid === 1'b1) begin
         if (lq.size() == 0) chk("ldr_rvalid_unexpected", 16'd1, 16'd0);
         else chk("ldr_rdata", bus.ldr_rdata, lq.pop_front());
      end
   end

   task automatic cyc(input logic rn, input logic fr, input logic [15:0] fa,
                      input logic lr, input logic lw, input logic [15:0] la, input logic [15:0] ld,
                      input logic efg, input logic elg, input logic ewe, input logic [15:0] ema,
                      input logic efv, input logic elv, input logic ewp);
      @(posedge clk);
      #1;
      resetn        = rn;
      bus.fetch_req  = fr;
      bus.fetch_addr = fa;
      bus.ldr_req    = lr;
      bus.ldr_we     = lw;
      bus.ldr_addr   = la;
      bus.ldr_wdata  = ld;
      exp_q.push_back('{fg: efg, lg: elg, we: ewe, ma: ema, fv: efv, lv: elv, wp: ewp});
   endtask

   // Pattern chars: L both req/loader wins, F both req/fetch wins, l loader only, f fetch only, - idle.
   task automatic run_pat(input string s, input logic [15:0] fa, input logic [15:0] la,
                          input logic [15:0] fd, input logic [15:0] ldv);
      byte c;
      byte prev = "-";
      logic fr, lr, fg, lg, fv, lv;
      for (int i = 0; i < s.len(); i++) begin
         c  = s[i];
         fr = (c == "L") || (c == "F") || (c == "f");
         lr = (c == "L") || (c == "F") || (c == "l");
         fg = (c == "F") || (c == "f");
         lg = (c == "L") || (c == "l");
         fv = (prev == "F") || (prev == "f");
         lv = (prev == "L") || (prev == "l");
         cyc(1'b1, fr, fa, lr, 1'b0, la, 16'h0, fg, lg, 1'b0, lg ? la : fa, fv, lv, 1'b0);
         if (fg) fq.push_back(fd);
         if (lg) lq.push_back(ldv);
         prev = c;
      end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
      mem[8'h05] = 16'h1234;
      mem[8'h08] = 16'h5555;
      mem[8'h30] = 16'h0A0A;
      bus.mem_dout   = 16'h0;
      resetn         = 1'b0;
      bus.fetch_req  = 1'b0;
      bus.fetch_addr = 16'h0;
      bus.ldr_req    = 1'b0;
      bus.ldr_we     = 1'b0;
      bus.ldr_addr   = 16'h0;
      bus.ldr_wdata  = 16'h0;

      // Reset: grants follow requests but memory is never written.
      cyc(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 16'h0, 1'b1, 1'b1, 16'h0020, 16'hBEEF, 1'b0, 1'b1, 1'b0, 16'h0020, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);

      run_pat("fff-", 16'h0005, 16'h0000, 16'h1234, 16'h0000);

      // Loader write then readback of the same word.
      cyc(1'b1, 1'b0, 16'h0, 1'b1, 1'b1, 16'h0020, 16'hBEEF, 1'b0, 1'b1, 1'b1, 16'h0020, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 16'h0, 1'b1, 1'b0, 16'h0020, 16'h0, 1'b0, 1'b1, 1'b0, 16'h0020, 1'b0, 1'b0, 1'b0);
      lq.push_back(16'hBEEF);
      cyc(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 1'b0);

      // Contention with fairness, then a fetch drop-out that restarts the burst window.
      run_pat("LLLLFLLLLFLLlLLLLF-", 16'h0005, 16'h0030, 16'h1234, 16'h0A0A);

      // Reset the cycle after a fetch grant; held fetch is granted at release.
      cyc(1'b1, 1'b1, 16'h0005, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 1'b0, 16'h0005, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, 16'h0005, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 1'b0, 16'h0005, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, 16'h0005, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 1'b0, 16'h0005, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 1'b1, 16'h0005, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 1'b0, 16'h0005, 1'b0, 1'b0, 1'b0);
      fq.push_back(16'h1234);
      cyc(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 1'b0);

      // Write below and at the protection limit, each followed by a readback.
      cyc(1'b1, 1'b0, 16'h0, 1'b1, 1'b1, 16'h0008, 16'hAAAA, 1'b0, 1'b1, !WP, 16'h0008, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 16'h0, 1'b1, 1'b0, 16'h0008, 16'h0, 1'b0, 1'b1, 1'b0, 16'h0008, 1'b0, 1'b0, WP);
      lq.push_back(WP ? 16'h5555 : 16'hAAAA);
      cyc(1'b1, 1'b0, 16'h0, 1'b1, 1'b1, 16'h0010, 16'hCCCC, 1'b0, 1'b1, 1'b1, 16'h0010, 1'b0, 1'b1, 1'b0);
      cyc(1'b1, 1'b0, 16'h0, 1'b1, 1'b0, 16'h0010, 16'h0, 1'b0, 1'b1, 1'b0, 16'h0010, 1'b0, 1'b0, 1'b0);
      lq.push_back(16'hCCCC);
      cyc(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 1'b0);
      cyc(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);

      @(negedge clk);
      #1;
      chk("cycle_queue_drained", 16'(exp_q.size()), 16'd0);
      chk("fetch_rdata_drained", 16'(fq.size()), 16'd0);
      chk("ldr_rdata_drained", 16'(lq.size()), 16'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
